// File: rtl/win_checker_pkg.sv
// Shared constants, cell codes, FSM encoding and the line-direction table
// used by the win checker and its probe-address helper.
package win_checker_pkg;

    localparam int ROWS    = 6;
    localparam int COLS    = 7;
    localparam int WIN_LEN = 4;
    localparam int CELLS   = ROWS * COLS;
    localparam int IDX_W   = 6;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] P1    = 2'b01;
    localparam logic [1:0] P2    = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POS,
        S_NEG,
        S_EVAL,
        S_DONE
    } state_t;

    // Scan order: horizontal, vertical, down-right diagonal, down-left diagonal
    typedef enum logic [1:0] {
        DIR_H,
        DIR_V,
        DIR_D1,
        DIR_D2
    } dir_t;

    function automatic logic signed [1:0] dir_dr(input dir_t d);
        return (d == DIR_H) ? 2'sd0 : 2'sd1;
    endfunction

    function automatic logic signed [1:0] dir_dc(input dir_t d);
        logic signed [1:0] dc;
        case (d)
            DIR_H:   dc = 2'sd1;
            DIR_V:   dc = 2'sd0;
            DIR_D1:  dc = 2'sd1;
            default: dc = -2'sd1;
        endcase
        return dc;
    endfunction

endpackage

// File: rtl/win_checker_board_addr.sv
// Combinational probe address: (row,col) + sign*k*(dr,dc), with a bounds flag.
// The index output is only meaningful while in_bounds is high.
module board_addr
    import win_checker_pkg::*;
(
    input  logic              [2:0]       row,
    input  logic              [2:0]       col,
    input  logic signed       [1:0]       dr,
    input  logic signed       [1:0]       dc,
    input  logic              [1:0]       k,
    input  logic                          sign,
    output logic                          in_bounds,
    output logic              [IDX_W-1:0] index
);

    logic signed [4:0] k_s;
    logic signed [4:0] dr_s;
    logic signed [4:0] dc_s;
    logic signed [4:0] off_r;
    logic signed [4:0] off_c;
    logic signed [4:0] r_s;
    logic signed [4:0] c_s;

    // Offset the anchor cell and range-check the result before forming the flat index
    always_comb begin
        k_s       = signed'({3'b000, k});
        dr_s      = {{3{dr[1]}}, dr};
        dc_s      = {{3{dc[1]}}, dc};
        off_r     = sign ? -(k_s * dr_s) : (k_s * dr_s);
        off_c     = sign ? -(k_s * dc_s) : (k_s * dc_s);
        r_s       = signed'({2'b00, row}) + off_r;
        c_s       = signed'({2'b00, col}) + off_c;
        in_bounds = !r_s[4] && !c_s[4] &&
                    (r_s[3:0] < 4'(ROWS)) && (c_s[3:0] < 4'(COLS));
        index     = IDX_W'(r_s[2:0]) * IDX_W'(COLS) + IDX_W'(c_s[2:0]);
    end

endmodule

// File: rtl/win_checker.sv
// Shadow-board win checker: records each accepted placement, walks the four
// lines through the new token one probe per cycle and reports win/draw.
module win_checker
    import win_checker_pkg::*;
(
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic       new_game,
    input  logic       place_valid,
    input  logic [2:0] place_row,
    input  logic [2:0] place_col,
    input  logic [1:0] place_player,
    output logic       busy,
    output logic       done,
    output logic       win,
    output logic [1:0] winner,
    output logic       draw,
    output logic       err
);

    state_t               state_q,  state_d;
    dir_t                 dir_q,    dir_d;
    logic [1:0]           k_q,      k_d;
    logic [2:0]           run_q,    run_d;
    logic [2*CELLS-1:0]   board_q,  board_d;
    logic [5:0]           count_q,  count_d;
    logic [2:0]           row_q,    row_d;
    logic [2:0]           col_q,    col_d;
    logic [1:0]           player_q, player_d;
    logic                 win_q,    win_d;
    logic [1:0]           winner_q, winner_d;
    logic                 draw_q,   draw_d;
    logic                 err_q,    err_d;

    logic [1:0]           cells [CELLS];
    logic                 probe_in;
    logic [IDX_W-1:0]     probe_idx;
    logic                 probe_hit;
    logic signed [1:0]    probe_dr;
    logic signed [1:0]    probe_dc;
    logic [IDX_W-1:0]     place_idx;
    logic                 place_ok;
    logic                 accept;

    // Per-cell view of the flat board vector
    for (genvar gi = 0; gi < CELLS; gi++) begin : g_cells
        assign cells[gi] = board_q[2*gi +: 2];
    end

    assign probe_dr = dir_dr(dir_q);
    assign probe_dc = dir_dc(dir_q);

    board_addr u_probe (
        .row       (row_q),
        .col       (col_q),
        .dr        (probe_dr),
        .dc        (probe_dc),
        .k         (k_q),
        .sign      (state_q == S_NEG),
        .in_bounds (probe_in),
        .index     (probe_idx)
    );

    assign probe_hit = probe_in && (cells[probe_idx] == player_q);

    assign place_idx = IDX_W'(place_row) * IDX_W'(COLS) + IDX_W'(place_col);
    // Range checks come first so an out-of-range index never decides the result
    assign place_ok  = (place_row < 3'(ROWS)) && (place_col < 3'(COLS)) &&
                       ((place_player == P1) || (place_player == P2)) &&
                       (cells[place_idx] == EMPTY);
    assign accept    = place_valid && (state_q == S_IDLE) && place_ok && !win_q && !draw_q;

    // Next-state: line scan sequencing, placement accept/reject, then new_game clear on top
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        k_d      = k_q;
        run_d    = run_q;
        board_d  = board_q;
        count_d  = count_q;
        row_d    = row_q;
        col_d    = col_q;
        player_d = player_q;
        win_d    = win_q;
        winner_d = winner_q;
        draw_d   = draw_q;
        err_d    = 1'b0;

        case (state_q)
            S_POS, S_NEG: begin
                if (probe_hit) begin
                    run_d = (run_q == 3'd7) ? run_q : run_q + 3'd1;
                end
                if (probe_hit && (k_q != 2'(WIN_LEN - 1))) begin
                    k_d = k_q + 2'd1;
                end else begin
                    k_d     = 2'd1;
                    state_d = (state_q == S_POS) ? S_NEG : S_EVAL;
                end
            end
            S_EVAL: begin
                if (run_q >= 3'(WIN_LEN)) begin
                    win_d    = 1'b1;
                    winner_d = player_q;
                    state_d  = S_DONE;
                end else if (dir_q == DIR_D2) begin
                    state_d = S_DONE;
                end else begin
                    dir_d   = dir_t'(dir_q + 2'd1);
                    k_d     = 2'd1;
                    run_d   = 3'd1;
                    state_d = S_POS;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if ((count_q == 6'(CELLS)) && !win_q) begin
                    draw_d = 1'b1;
                end
            end
            default: ;
        endcase

        if (place_valid) begin
            if (accept) begin
                board_d[2*place_idx +: 2] = place_player;
                count_d  = count_q + 6'd1;
                row_d    = place_row;
                col_d    = place_col;
                player_d = place_player;
                dir_d    = DIR_H;
                k_d      = 2'd1;
                run_d    = 3'd1;
                state_d  = S_POS;
            end else begin
                err_d = 1'b1;
            end
        end

        if (new_game) begin
            state_d  = S_IDLE;
            dir_d    = DIR_H;
            k_d      = 2'd1;
            run_d    = 3'd1;
            board_d  = '0;
            count_d  = '0;
            row_d    = '0;
            col_d    = '0;
            player_d = EMPTY;
            win_d    = 1'b0;
            winner_d = EMPTY;
            draw_d   = 1'b0;
            err_d    = 1'b0;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= S_IDLE;
            dir_q    <= DIR_H;
            k_q      <= 2'd1;
            run_q    <= 3'd1;
            board_q  <= '0;
            count_q  <= '0;
            row_q    <= '0;
            col_q    <= '0;
            player_q <= EMPTY;
            win_q    <= 1'b0;
            winner_q <= EMPTY;
            draw_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            k_q      <= k_d;
            run_q    <= run_d;
            board_q  <= board_d;
            count_q  <= count_d;
            row_q    <= row_d;
            col_q    <= col_d;
            player_q <= player_d;
            win_q    <= win_d;
            winner_q <= winner_d;
            draw_q   <= draw_d;
            err_q    <= err_d;
        end
    end

    assign busy   = (state_q == S_POS) || (state_q == S_NEG) || (state_q == S_EVAL);
    assign done   = (state_q == S_DONE);
    assign win    = win_q;
    assign winner = winner_q;
    assign draw   = draw_q;
    assign err    = err_q;

endmodule

// File: tb/tb_win_checker.sv
// Scoreboard bench for win_checker: stimulus pushes expected responses computed
// from a whole-board reference model; a monitor pops them on done/err pulses.
module tb_win_checker;

    localparam int NR = 6;
    localparam int NC = 7;
    localparam int MAX_LAT = 29;

    logic       CLOCK_50 = 1'b0;
    logic       Resetn = 1'b0;
    logic       new_game = 1'b0;
    logic       place_valid = 1'b0;
    logic [2:0] place_row = '0;
    logic [2:0] place_col = '0;
    logic [1:0] place_player = '0;
    logic       busy, done, win, draw, err;
    logic [1:0] winner;

    win_checker dut (
        .CLOCK_50     (CLOCK_50),
        .Resetn       (Resetn),
        .new_game     (new_game),
        .place_valid  (place_valid),
        .place_row    (place_row),
        .place_col    (place_col),
        .place_player (place_player),
        .busy         (busy),
        .done         (done),
        .win          (win),
        .winner       (winner),
        .draw         (draw),
        .err          (err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    typedef struct {
        int win;
        int winner;
        int draw;
        int issue;
    } exp_t;

    exp_t done_q[$];
    int   err_q[$];
    int   compared = 0;
    int   mismatched = 0;

    // reference model
    int board [NR][NC];
    int mcount, mwin, mwinner, mdraw;

    int draw_chk = 0;
    int draw_exp = 0;

    task automatic check(input string name, input int act, input int expv);
        compared++;
        if (act != expv) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Any WIN_LEN-long straight line anywhere on the board owned by p
    function automatic int line_win(input int p);
        int dr[4] = '{0, 1, 1, 1};
        int dc[4] = '{1, 0, 1, -1};
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                for (int d = 0; d < 4; d++) begin
                    int ok = 1;
                    for (int k = 0; k < 4; k++) begin
                        int rr = r + k * dr[d];
                        int cc = c + k * dc[d];
                        if (rr < 0 || rr >= NR || cc < 0 || cc >= NC) ok = 0;
                        else if (board[rr][cc] != p) ok = 0;
                    end
                    if (ok != 0) return 1;
                end
        return 0;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                board[r][c] = 0;
        mcount = 0; mwin = 0; mwinner = 0; mdraw = 0;
        done_q.delete();
        err_q.delete();
        draw_chk = 0;
    endtask

    task automatic place(input int r, input int c, input int p);
        int rej;
        @(posedge CLOCK_50); #1;
        place_row = 3'(r); place_col = 3'(c); place_player = 2'(p);
        place_valid = 1'b1;
        rej = (done_q.size() > 0) || (mwin != 0) || (mdraw != 0) ||
              (r >= NR) || (c >= NC) || (p != 1 && p != 2);
        if (rej == 0 && board[r][c] != 0) rej = 1;
        if (rej != 0) begin
            err_q.push_back(cyc);
        end else begin
            board[r][c] = p;
            mcount++;
            if (line_win(p) != 0) begin mwin = 1; mwinner = p; end
            mdraw = (mcount == NR * NC && mwin == 0) ? 1 : 0;
            done_q.push_back('{mwin, mwinner, mdraw, cyc});
        end
        @(posedge CLOCK_50); #1;
        place_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && done_q.size() > 0; i++) @(posedge CLOCK_50);
        if (done_q.size() > 0) begin
            compared++; mismatched++;
            $display("FAIL done_timeout: got no done in 60 cycles, expected done");
            done_q.delete();
        end
        repeat (2) @(posedge CLOCK_50);
        #1;
        check("err_outstanding", err_q.size(), 0);
        err_q.delete();
    endtask

    task automatic check_cleared(input string name);
        @(negedge CLOCK_50);
        check(name, int'({busy, done, win, winner, draw, err}), 0);
    endtask

    task automatic start_new_game();
        @(posedge CLOCK_50); #1;
        new_game = 1'b1;
        @(posedge CLOCK_50); #1;
        new_game = 1'b0;
        model_clear();
        check_cleared("new_game_clear");
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents done or err
    initial begin
        exp_t e;
        int   ie;
        forever begin
            @(negedge CLOCK_50);
            if (Resetn) begin
                if (draw_chk != 0) begin
                    check("draw", int'(draw), draw_exp);
                    draw_chk = 0;
                end
                if (done) begin
                    if (done_q.size() == 0) begin
                        compared++; mismatched++;
                        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
                    end else begin
                        e = done_q.pop_front();
                        $display("[%0d] done win=%0d winner=%0d latency=%0d", cyc, win, winner, cyc - e.issue);
                        check("win", int'(win), e.win);
                        check("winner", int'(winner), e.winner);
                        check("latency_ok", int'((cyc - e.issue) <= MAX_LAT), 1);
                        draw_chk = 1;
                        draw_exp = e.draw;
                    end
                end
                if (err) begin
                    if (err_q.size() == 0) begin
                        compared++; mismatched++;
                        $display("FAIL unexpected_err: got err=1 at cycle %0d, expected none", cyc);
                    end else begin
                        ie = err_q.pop_front();
                        $display("[%0d] err latency=%0d", cyc, cyc - ie);
                        check("err_latency", cyc - ie, 1);
                    end
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pl, r, c, p, kind;
        model_clear();

        // Reset state, then reset asserted in the middle of a scan
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("reset_outputs", int'({busy, done, win, winner, draw, err}), 0);
        @(negedge CLOCK_50) Resetn = 1'b1;
        check_cleared("post_reset_idle");
        place(5, 3, 1);
        repeat (3) @(posedge CLOCK_50);
        #2;
        check("busy_mid_scan", int'(busy), 1);
        Resetn = 1'b0;
        #1;
        check("async_reset_outputs", int'({busy, done, win, winner, draw, err}), 0);
        model_clear();
        @(negedge CLOCK_50) Resetn = 1'b1;
        repeat (40) @(posedge CLOCK_50);

        // Vertical win in column 3
        start_new_game();
        for (int i = 0; i < 3; i++) begin
            place(5 - i, 3, 1);
            wait_idle();
            check("vert_partial_win", int'(win), 0);
        end
        place(2, 3, 1);
        wait_idle();
        check("vert_win", int'(win), 1);
        check("vert_winner", int'(winner), 1);

        // Anti-diagonal built out of order, middle token completes it
        start_new_game();
        place(5, 0, 2); wait_idle();
        place(3, 2, 2); wait_idle();
        place(2, 3, 2); wait_idle();
        check("diag_partial_win", int'(win), 0);
        place(4, 1, 2); wait_idle();
        check("diag_win", int'(win), 1);
        check("diag_winner", int'(winner), 2);

        // Right-edge run, then completion at the left end; then place after win
        start_new_game();
        place(5, 4, 1); wait_idle();
        place(5, 5, 1); wait_idle();
        place(5, 6, 1); wait_idle();
        check("edge_partial_win", int'(win), 0);
        place(5, 3, 1); wait_idle();
        check("edge_win", int'(win), 1);
        place(0, 0, 2); wait_idle();

        // Rejects: occupied, col 7, player 11/00, during busy; board unchanged after
        start_new_game();
        place(5, 3, 1); wait_idle();
        place(5, 3, 2); wait_idle();
        place(5, 7, 1); wait_idle();
        place(0, 0, 3); wait_idle();
        place(0, 0, 0); wait_idle();
        place(0, 0, 1);
        place(1, 1, 2);
        wait_idle();
        place(1, 1, 2); wait_idle();

        // new_game together with place_valid: clear wins, placement dropped
        @(posedge CLOCK_50); #1;
        new_game = 1'b1; place_valid = 1'b1;
        place_row = 3'd4; place_col = 3'd4; place_player = 2'd1;
        @(posedge CLOCK_50); #1;
        new_game = 1'b0; place_valid = 1'b0;
        model_clear();
        check_cleared("simul_clear");
        place(5, 3, 2); wait_idle();

        // new_game mid-scan aborts without done
        place(0, 6, 1);
        repeat (3) @(posedge CLOCK_50);
        start_new_game();
        repeat (40) @(posedge CLOCK_50);

        // Full board with no line of four
        start_new_game();
        for (int rr = 0; rr < NR; rr++)
            for (int cc = 0; cc < NC; cc++) begin
                place(rr, cc, 1 + (((rr / 2) + cc) % 2));
                wait_idle();
            end
        check("draw_set", int'(draw), 1);
        check("draw_no_win", int'(win), 0);
        place(0, 0, 1); wait_idle();
        start_new_game();
        place(5, 0, 1); wait_idle();

        // Randomised gravity games with occasional illegal moves
        for (int g = 0; g < 6; g++) begin
            start_new_game();
            pl = 1;
            for (int m = 0; m < 60 && mwin == 0 && mdraw == 0; m++) begin
                kind = int'($urandom_range(0, 9));
                c = int'($urandom_range(0, NC - 1));
                r = 0;
                for (int x = NR - 1; x >= 0; x--)
                    if (board[x][c] == 0) begin r = x; break; end
                p = pl;
                if (kind == 0) p = ($urandom_range(0, 1) != 0) ? 3 : 0;
                if (kind == 1) c = 7;
                if (kind >= 2 && board[r][c] == 0) pl = 3 - pl;
                place(r, c, p);
                wait_idle();
            end
            place(0, 0, pl);
            wait_idle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
